// File: rtl/spi_boot_ctrl.sv
// spi_boot_ctrl: SPI boot loader that validates a header frame, then writes the image into instruction memory.
// Holds the core in reset until the image has been written; all outputs are registered.
module spi_boot_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [7:0] MAGIC = 8'hA5,
  parameter logic [15:0] MAX_WORDS = 16'd4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SS,
  input  logic [DATA_WIDTH-1:0] REG_DIN,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  output logic                  core_rst,
  output logic                  boot_done,
  output logic                  boot_err,
  output logic [15:0]           words_loaded
);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [2:0] ss_q;
  logic fe_q, ovr_q, ovr_d, req_q, req_d, crst_q, crst_d, done_q, done_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] word_q, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d, words_q, words_d;
  logic hdr_ok;
  assign hdr_ok = (word_q[31:24] == MAGIC) && (word_q[15:0] <= MAX_WORDS);
  always_comb begin
    state_d = state_q;
    ovr_d = ovr_q;
    req_d = req_q;
    crst_d = crst_q;
    done_d = done_q;
    err_d = err_q;
    wdata_d = wdata_q;
    addr_d = addr_q;
    rem_d = rem_q;
    words_d = words_q;
    case (state_q)
      IDLE, ERROR: if (fe_q) begin
        if (!hdr_ok) begin
          state_d = ERROR;
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
          ovr_d = 1'b0;
          words_d = '0;
          addr_d = BASE_ADDR;
          rem_d = word_q[15:0];
          state_d = (word_q[15:0] == 16'd0) ? DONE : LOAD;
          done_d = (word_q[15:0] == 16'd0);
          crst_d = (word_q[15:0] != 16'd0);
        end
      end
      LOAD: if (fe_q) begin
        wdata_d = word_q;
        req_d = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        ovr_d = ovr_q | fe_q;
        if (mem_gnt) begin
          req_d = 1'b0;
          addr_d = addr_q + ADDR_WIDTH'(4);
          rem_d = rem_q - 16'd1;
          words_d = words_q + 16'd1;
          // A frame that completed while we were stalled has already been lost.
          if (ovr_q | fe_q) begin
            state_d = ERROR;
            err_d = 1'b1;
          end else if (rem_q == 16'd1) begin
            state_d = DONE;
            done_d = 1'b1;
            crst_d = 1'b0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_q <= 3'b111;
      fe_q <= 1'b0;
      word_q <= '0;
      state_q <= IDLE;
      ovr_q <= 1'b0;
      req_q <= 1'b0;
      crst_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
      wdata_q <= '0;
      addr_q <= BASE_ADDR;
      rem_q <= '0;
      words_q <= '0;
    end else begin
      ss_q <= {ss_q[1:0], SS};
      fe_q <= ss_q[1] & ~ss_q[2];
      word_q <= (ss_q[1] & ~ss_q[2]) ? REG_DIN : word_q;
      state_q <= state_d;
      ovr_q <= ovr_d;
      req_q <= req_d;
      crst_q <= crst_d;
      done_q <= done_d;
      err_q <= err_d;
      wdata_q <= wdata_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      words_q <= words_d;
    end
  end
  assign mem_req = req_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign core_rst = crst_q;
  assign boot_done = done_q;
  assign boot_err = err_q;
  assign words_loaded = words_q;
endmodule

// File: tb/tb_spi_boot_ctrl.sv
// tb_spi_boot_ctrl: directed table-driven bench for spi_boot_ctrl with a negedge write monitor.
module tb_spi_boot_ctrl;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk = 1'b0, reset = 1'b1, SS = 1'b1, mem_gnt = 1'b0;
  logic [31:0] REG_DIN = '0;
  logic mem_req, core_rst, boot_done, boot_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_loaded;
  int total = 0, passed = 0, req_cycles = 0;
  logic [31:0] wa[$], wd[$];
  typedef struct {
    logic [31:0] hdr;
    int nd;
    logic [31:0] d0;
    logic done, err, crst;
    int words;
  } vec_t;
  vec_t tbl[7];
  spi_boot_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .SS(SS), .REG_DIN(REG_DIN),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .core_rst(core_rst), .boot_done(boot_done), .boot_err(boot_err), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!reset) begin
    if (mem_req) req_cycles++;
    if (mem_req && mem_gnt) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
    else passed++;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    SS = 1'b1;
    mem_gnt = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wa.delete();
    wd.delete();
    req_cycles = 0;
  endtask
  task automatic send_frame(input logic [31:0] v);
    @(posedge clk);
    #1 REG_DIN = v;
    SS = 1'b0;
    repeat (4) @(posedge clk);
    #1 SS = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask
  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_req", 32'(mem_req), 32'd1);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_addr"}, mem_addr, BASE);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, "_done"}, 32'(boot_done), 32'd0);
    chk({tag, "_err"}, 32'(boot_err), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask
  initial begin
    tbl[0] = '{32'hA500_0003, 3, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 3};
    tbl[1] = '{32'h5A00_0002, 0, 32'h0, 1'b0, 1'b1, 1'b1, 0};
    tbl[2] = '{32'hA500_0000, 0, 32'h0, 1'b1, 1'b0, 1'b0, 0};
    tbl[3] = '{32'hA5FF_0001, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1};
    tbl[4] = '{32'hA500_1001, 0, 32'h0, 1'b0, 1'b1, 1'b1, 0};
    tbl[5] = '{32'hA500_1000, 0, 32'h0, 1'b0, 1'b0, 1'b1, 0};
    tbl[6] = '{32'hA500_0002, 2, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 2};
    do_reset();
    chk_reset_vals("rst");
    for (int i = 0; i < 7; i++) begin
      do_reset();
      mem_gnt = 1'b1;
      send_frame(tbl[i].hdr);
      for (int k = 0; k < tbl[i].nd; k++) send_frame(tbl[i].d0 + 32'(k) * 32'h1111_1111);
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("v%0d_done", i), 32'(boot_done), 32'(tbl[i].done));
      chk($sformatf("v%0d_err", i), 32'(boot_err), 32'(tbl[i].err));
      chk($sformatf("v%0d_core_rst", i), 32'(core_rst), 32'(tbl[i].crst));
      chk($sformatf("v%0d_words", i), 32'(words_loaded), 32'(tbl[i].words));
      chk($sformatf("v%0d_nwrites", i), 32'(wa.size()), 32'(tbl[i].words));
      chk($sformatf("v%0d_req_cycles", i), 32'(req_cycles), 32'(tbl[i].words));
      for (int k = 0; k < tbl[i].words && k < wa.size(); k++) begin
        chk($sformatf("v%0d_addr%0d", i, k), wa[k], BASE + 32'(4 * k));
        chk($sformatf("v%0d_data%0d", i, k), wd[k], tbl[i].d0 + 32'(k) * 32'h1111_1111);
      end
    end
    // final grant edge: done/core_rst/req all flip on the same edge
    do_reset();
    mem_gnt = 1'b1;
    send_frame(32'hA500_0001);
    @(posedge clk);
    #1 REG_DIN = 32'h0BAD_F00D;
    SS = 1'b0;
    repeat (4) @(posedge clk);
    #1 SS = 1'b1;
    wait_req();
    chk("edge_done_before", 32'(boot_done), 32'd0);
    chk("edge_rst_before", 32'(core_rst), 32'd1);
    @(posedge clk);
    #1;
    chk("edge_done_after", 32'(boot_done), 32'd1);
    chk("edge_rst_after", 32'(core_rst), 32'd0);
    chk("edge_req_after", 32'(mem_req), 32'd0);
    // bad magic then recovery
    do_reset();
    mem_gnt = 1'b1;
    send_frame(32'h5A00_0002);
    chk("bm_err", 32'(boot_err), 32'd1);
    chk("bm_core_rst", 32'(core_rst), 32'd1);
    send_frame(32'hA500_0001);
    chk("bm_err_cleared", 32'(boot_err), 32'd0);
    send_frame(32'hDEAD_BEEF);
    chk("bm_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) begin
      chk("bm_addr", wa[0], BASE);
      chk("bm_data", wd[0], 32'hDEAD_BEEF);
    end
    chk("bm_done", 32'(boot_done), 32'd1);
    chk("bm_err_final", 32'(boot_err), 32'd0);
    // zero length, later frames ignored
    do_reset();
    mem_gnt = 1'b1;
    send_frame(32'hA500_0000);
    send_frame(32'hA500_0005);
    send_frame(32'h1234_5678);
    chk("zl_done", 32'(boot_done), 32'd1);
    chk("zl_words", 32'(words_loaded), 32'd0);
    chk("zl_req_cycles", 32'(req_cycles), 32'd0);
    // stalled grant
    do_reset();
    send_frame(32'hA500_0002);
    send_frame(32'h5555_AAAA);
    wait_req();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("st_req", 32'(mem_req), 32'd1);
      chk("st_addr", mem_addr, BASE);
      chk("st_wdata", mem_wdata, 32'h5555_AAAA);
    end
    chk("st_nowrite", 32'(wa.size()), 32'd0);
    @(posedge clk);
    #1 mem_gnt = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("st_one_write", 32'(wa.size()), 32'd1);
    chk("st_words1", 32'(words_loaded), 32'd1);
    send_frame(32'h6666_BBBB);
    chk("st_nwrites", 32'(wa.size()), 32'd2);
    if (wa.size() > 1) begin
      chk("st_addr1", wa[1], BASE + 32'd4);
      chk("st_data1", wd[1], 32'h6666_BBBB);
    end
    chk("st_done", 32'(boot_done), 32'd1);
    // overrun
    do_reset();
    send_frame(32'hA500_0002);
    send_frame(32'hAAAA_0001);
    wait_req();
    send_frame(32'hBBBB_0002);
    chk("ov_err_pending", 32'(boot_err), 32'd0);
    chk("ov_req_held", 32'(mem_req), 32'd1);
    chk("ov_wdata_held", mem_wdata, 32'hAAAA_0001);
    @(posedge clk);
    #1 mem_gnt = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("ov_err", 32'(boot_err), 32'd1);
    chk("ov_req", 32'(mem_req), 32'd0);
    chk("ov_words", 32'(words_loaded), 32'd1);
    chk("ov_core_rst", 32'(core_rst), 32'd1);
    chk("ov_done", 32'(boot_done), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("ov_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) chk("ov_data", wd[0], 32'hAAAA_0001);
    // reset mid-load, asynchronous drop of the request
    do_reset();
    send_frame(32'hA500_0004);
    send_frame(32'h7777_0001);
    wait_req();
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("ar");
    @(posedge clk);
    #1 reset = 1'b0;
    wa.delete();
    wd.delete();
    mem_gnt = 1'b1;
    send_frame(32'hA500_0001);
    send_frame(32'h1234_5678);
    chk("ar_nwrites", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) begin
      chk("ar_addr", wa[0], BASE);
      chk("ar_data", wd[0], 32'h1234_5678);
    end
    chk("ar_done", 32'(boot_done), 32'd1);
    chk("ar_words", 32'(words_loaded), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
